muldiv_seq: RTL and testbench

//   Multi-cycle sequencer for ALU mult (alucontrol 4'b0010) and div (4'b0011).

---
 rtl/muldiv_seq.sv | 149 ++++++++++++++
 tb/tb_muldiv_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply / divide sequencer beside the single-cycle ALU.
// Iterative shift-add multiply and restoring divide, one bit per clock.
module muldiv_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             divzero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam logic [3:0]  OP_MUL = 4'b0010;
  localparam logic [3:0]  OP_DIV = 4'b0011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               divzero_q, divzero_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     mul_sum;
  logic [ACC_W-1:0]   mul_step;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [ACC_W-1:0]   div_step;

  // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = acc_q[ACC_W-1:WIDTH-1];
    div_trial = div_shift - {1'b0, opnd_q};
    // remainder stays below divisor, so the trial borrow bit is the compare result
    div_ge    = ~div_trial[WIDTH];
    div_step  = {(div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    hi_d      = hi_q;
    divzero_d = divzero_q;

    case (state_q)
      S_IDLE: begin
        if (start && (alucontrol == OP_MUL || alucontrol == OP_DIV)) begin
          cnt_d     = CNT_W'(WIDTH);
          divzero_d = 1'b0;
          if (alucontrol == OP_MUL) begin
            opnd_d  = a;
            acc_d   = {WIDTH'(0), b};
            state_d = S_MUL;
          end else begin
            opnd_d  = b;
            acc_d   = {WIDTH'(0), a};
            if (b == WIDTH'(0)) begin
              state_d   = S_DONE;
              divzero_d = 1'b1;
              result_d  = {WIDTH{1'b1}};
              hi_d      = a;
            end else begin
              state_d = S_DIV;
            end
          end
        end
      end
      S_MUL: begin
        acc_d = mul_step;
        if (cnt_q != CNT_W'(0)) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          result_d = mul_step[WIDTH-1:0];
          hi_d     = mul_step[ACC_W-1:WIDTH];
        end
      end
      S_DIV: begin
        acc_d = div_step;
        if (cnt_q != CNT_W'(0)) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          result_d = div_step[WIDTH-1:0];
          hi_d     = div_step[ACC_W-1:WIDTH];
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
      hi_q      <= '0;
      divzero_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      divzero_q <= divzero_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign hi      = hi_q;
  assign divzero = divzero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results queued at accept, checked at done.
module tb_muldiv_seq;

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  alucontrol;
  logic [15:0] a, b;
  logic        ready, busy, done, divzero;
  logic [15:0] result, hi;

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ncyc = 0;
  logic [15:0] last_res = '0, last_hi = '0;
  logic        last_dz = 1'b0;

  muldiv_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alucontrol(alucontrol),
    .a(a), .b(b), .ready(ready), .busy(busy), .done(done),
    .result(result), .hi(hi), .divzero(divzero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin : mon_blk
    exp_t e;
    ncyc++;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", done, 0);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("hi", hi, e.hi);
        check("divzero", divzero, e.dz);
        check("latency", ncyc - e.acc, e.lat);
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [15:0] ai, input logic [15:0] bi,
                       input logic [15:0] er, input logic [15:0] eh, input logic edz,
                       input int lat, input int poke_at, input int rst_at);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", ready, 1);
    start = 1'b1; alucontrol = op; a = ai; b = bi;
    @(posedge clk);
    #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    e.res = er; e.hi = eh; e.dz = edz; e.lat = lat; e.acc = ncyc;
    sb.push_back(e);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_hi", hi, 0);
        check("rst_divzero", divzero, 0);
        sb.delete();
        last_res = '0; last_hi = '0; last_dz = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k == poke_at) begin
        start = 1'b1; alucontrol = OP_DIV; b = '0;
      end else begin
        start = 1'b0;
      end
      if (k <= lat) begin
        check("busy_run", busy, 1);
        check("ready_run", ready, 0);
      end else begin
        check("busy_after", busy, 0);
        check("ready_after", ready, 1);
        check("sb_drained", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
      end
    end
    last_res = er; last_hi = eh; last_dz = edz;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] ra, rb;
    logic [31:0] p;
    logic [3:0]  op;
    rst_n = 1'b0; start = 1'b0; alucontrol = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_hi", hi, 0);
    check("reset_divzero", divzero, 0);
    rst_n = 1'b1;

    do_op(OP_MUL, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 17, 0, 0);
    do_op(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17, 0, 0);
    do_op(OP_DIV, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 0, 0);
    do_op(OP_DIV, 16'h0042, 16'h0000, 16'hFFFF, 16'h0042, 1'b1, 1, 0, 0);

    // non-mult/div opcode must be ignored with outputs held
    @(negedge clk);
    start = 1'b1; alucontrol = 4'b0000; a = 16'h0005; b = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      check("ign_ready", ready, 1);
      check("ign_busy", busy, 0);
      check("ign_done", done, 0);
      check("ign_result", result, last_res);
      check("ign_hi", hi, last_hi);
      check("ign_divzero", divzero, last_dz);
    end
    start = 1'b0;

    // start pulsed mid-run must not disturb the product
    do_op(OP_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 1'b0, 17, 5, 0);

    do_op(OP_MUL, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 17, 0, 5);
    do_op(OP_DIV, 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17, 0, 0);

    do_op(OP_DIV, 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 17, 0, 0);
    do_op(OP_DIV, 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17, 0, 0);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = (i == 3) ? 16'h0000 : 16'($urandom);
      op = i[0] ? OP_DIV : OP_MUL;
      if (i == 3) op = OP_DIV;
      if (op == OP_MUL) begin
        p = 32'(ra) * 32'(rb);
        do_op(op, ra, rb, p[15:0], p[31:16], 1'b0, 17, 0, 0);
      end else if (rb == 16'h0000) begin
        do_op(op, ra, rb, 16'hFFFF, ra, 1'b1, 1, 0, 0);
      end else begin
        do_op(op, ra, rb, ra / rb, ra % rb, 1'b0, 17, 0, 0);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
